// File: rtl/bf_pkg.sv
// Definitions shared by the systolic array top and the partial-sum accumulator:
// FSM states, default geometry, and the per-lane shift/ReLU/saturate step.
package bf_pkg;

   localparam int BF_ARRAY_SIZE = 8;
   localparam int BF_COL_WIDTH  = 13;
   localparam int BF_ACC_WIDTH  = 64;
   localparam int BF_OUT_WIDTH  = 16;
   localparam int SHIFT_W       = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      POST  = 2'd2,
      DRAIN = 2'd3
   } state_e;

   localparam logic signed [BF_ACC_WIDTH-1:0] SAT_MAX =
      {{(BF_ACC_WIDTH-BF_OUT_WIDTH+1){1'b0}}, {(BF_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [BF_ACC_WIDTH-1:0] SAT_MIN =
      {{(BF_ACC_WIDTH-BF_OUT_WIDTH+1){1'b1}}, {(BF_OUT_WIDTH-1){1'b0}}};

   // Arithmetic shift rounds toward -inf; ReLU is applied before clamping.
   function automatic logic signed [BF_OUT_WIDTH-1:0] sat_shift(
      input logic signed [BF_ACC_WIDTH-1:0] acc,
      input logic        [SHIFT_W-1:0]      shift,
      input logic                           relu_en
   );
      logic signed [BF_ACC_WIDTH-1:0] r;
      r = acc >>> shift;
      if (relu_en && r[BF_ACC_WIDTH-1]) begin
         r = '0;
      end
      if (r > SAT_MAX) begin
         sat_shift = {1'b0, {(BF_OUT_WIDTH-1){1'b1}}};
      end else if (r < SAT_MIN) begin
         sat_shift = {1'b1, {(BF_OUT_WIDTH-1){1'b0}}};
      end else begin
         sat_shift = r[BF_OUT_WIDTH-1:0];
      end
   endfunction

endpackage

// File: rtl/psum_lane.sv
// One psum lane: sign-extending accumulator followed by a registered
// shift / ReLU / saturate result.
module psum_lane
   import bf_pkg::*;
#(
   parameter int COL_WIDTH = BF_COL_WIDTH,
   parameter int ACC_WIDTH = BF_ACC_WIDTH,
   parameter int OUT_WIDTH = BF_OUT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clr_i,
   input  logic                          acc_en_i,
   input  logic                          post_en_i,
   input  logic        [SHIFT_W-1:0]     shift_i,
   input  logic                          relu_en_i,
   input  logic signed [4*COL_WIDTH-1:0] psum_i,
   output logic signed [OUT_WIDTH-1:0]   out_o
);

   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic signed [OUT_WIDTH-1:0] out_q, out_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (acc_en_i) begin
         acc_d = acc_q + ACC_WIDTH'(psum_i);
      end
   end

   always_comb begin
      out_d = out_q;
      if (post_en_i) begin
         out_d = sat_shift(acc_q, shift_i, relu_en_i);
      end
   end

   // Accumulate stage feeds the post-process register one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         out_q <= '0;
      end else begin
         acc_q <= acc_d;
         out_q <= out_d;
      end
   end

   assign out_o = out_q;

endmodule

// File: rtl/psum_accumulator.sv
// K-tiled partial-sum accumulator: sums num_tiles psum vectors per job, then
// emits one shifted / ReLU'd / saturated vector over a valid/ready handshake.
module psum_accumulator
   import bf_pkg::*;
#(
   parameter int ARRAY_SIZE = BF_ARRAY_SIZE,
   parameter int COL_WIDTH  = BF_COL_WIDTH,
   parameter int ACC_WIDTH  = BF_ACC_WIDTH,
   parameter int OUT_WIDTH  = BF_OUT_WIDTH
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                start,
   input  logic [15:0]                         num_tiles,
   input  logic [SHIFT_W-1:0]                  shift,
   input  logic                                relu_en,
   input  logic [ARRAY_SIZE*4*COL_WIDTH-1:0]   psum_in,
   input  logic                                psum_valid,
   output logic                                psum_ready,
   output logic [ARRAY_SIZE*OUT_WIDTH-1:0]     out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                busy,
   output logic                                done
);

   localparam int LANE_W = 4 * COL_WIDTH;

   state_e              state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [15:0]         tiles_q, tiles_d;
   logic [SHIFT_W-1:0]  shift_q, shift_d;
   logic                relu_q, relu_d;
   logic                done_q, done_d;
   logic                clr, beat, post_en;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tiles_d = tiles_q;
      shift_d = shift_q;
      relu_d  = relu_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      beat    = 1'b0;
      post_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               tiles_d = (num_tiles == 16'd0) ? 16'd1 : num_tiles;
               shift_d = shift;
               relu_d  = relu_en;
               cnt_d   = '0;
               clr     = 1'b1;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (psum_valid) begin
               beat  = 1'b1;
               cnt_d = cnt_q + 16'd1;
               if (cnt_d == tiles_q) begin
                  state_d = POST;
               end
            end
         end
         POST: begin
            post_en = 1'b1;
            state_d = DRAIN;
         end
         DRAIN: begin
            if (out_ready) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tiles_q <= '0;
         shift_q <= '0;
         relu_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tiles_q <= tiles_d;
         shift_q <= shift_d;
         relu_q  <= relu_d;
         done_q  <= done_d;
      end
   end

   assign psum_ready = (state_q == ACCUM);
   assign out_valid  = (state_q == DRAIN);
   assign busy       = (state_q != IDLE);
   assign done       = done_q;

   for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
      psum_lane #(
         .COL_WIDTH (COL_WIDTH),
         .ACC_WIDTH (ACC_WIDTH),
         .OUT_WIDTH (OUT_WIDTH)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr_i     (clr),
         .acc_en_i  (beat),
         .post_en_i (post_en),
         .shift_i   (shift_q),
         .relu_en_i (relu_q),
         .psum_i    (psum_in[i*LANE_W +: LANE_W]),
         .out_o     (out_data[i*OUT_WIDTH +: OUT_WIDTH])
      );
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with hand-computed expected lane values.
module tb_psum_accumulator;

   localparam int N  = 8;
   localparam int CW = 13;
   localparam int LW = 4 * CW;
   localparam int OW = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic [15:0]        num_tiles;
   logic [5:0]         shift;
   logic               relu_en;
   logic [N*LW-1:0]    psum_in;
   logic               psum_valid;
   logic               psum_ready;
   logic [N*OW-1:0]    out_data;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
   logic               done;

   int checks = 0;
   int errors = 0;

   psum_accumulator dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_tiles  (num_tiles),
      .shift      (shift),
      .relu_en    (relu_en),
      .psum_in    (psum_in),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint lane(input int i);
      logic signed [OW-1:0] t;
      t = out_data[i*OW +: OW];
      return longint'(t);
   endfunction

   task automatic set_lane(input int i, input int v);
      psum_in[i*LW +: LW] = LW'(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int nt, input int sh, input bit relu);
      num_tiles = 16'(nt);
      shift     = 6'(sh);
      relu_en   = relu;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic beat();
      psum_valid = 1'b1;
      step();
      psum_valid = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 10) begin
         step();
         n++;
      end
      check({tag, "_out_valid"}, longint'(out_valid), 1);
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_done"}, longint'(done), 1);
      check({tag, "_idle"}, longint'(busy), 0);
      step();
      check({tag, "_done_low"}, longint'(done), 0);
   endtask

   initial begin
      int pat[5] = '{1, 0, 1, 0, 1};
      rst_n = 1'b0; start = 1'b0; num_tiles = '0; shift = '0; relu_en = 1'b0;
      psum_in = '0; psum_valid = 1'b0; out_ready = 1'b0;
      step(); step();
      check("rst_psum_ready", longint'(psum_ready), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(done), 0);
      check("rst_out_data", longint'(out_data == '0), 1);
      rst_n = 1'b1;
      step();

      // Basic accumulation 10 + 20 - 5.
      start_job(3, 0, 1'b0);
      check("basic_psum_ready", longint'(psum_ready), 1);
      set_lane(0, 10);  beat();
      set_lane(0, 20);  beat();
      set_lane(0, -5);  beat();
      check("basic_post_no_valid", longint'(out_valid), 0);
      check("basic_post_not_ready", longint'(psum_ready), 0);
      check("basic_post_busy", longint'(busy), 1);
      step();
      check("basic_valid_latency", longint'(out_valid), 1);
      check("basic_lane0", lane(0), 25);
      check("basic_lane1", lane(1), 0);
      handshake("basic");

      // Shift with ReLU, then without, then floor rounding.
      psum_in = '0;
      start_job(1, 2, 1'b1);
      set_lane(1, -100); set_lane(2, 100); beat();
      wait_valid("relu");
      check("relu_lane1", lane(1), 0);
      check("relu_lane2", lane(2), 25);
      handshake("relu");
      start_job(1, 2, 1'b0);
      beat();
      wait_valid("norelu");
      check("norelu_lane1", lane(1), -25);
      check("norelu_lane2", lane(2), 25);
      handshake("norelu");
      psum_in = '0;
      start_job(1, 1, 1'b0);
      set_lane(0, -7); beat();
      wait_valid("floor");
      check("floor_lane0", lane(0), -4);
      handshake("floor");

      // Saturation both directions on every lane.
      for (int i = 0; i < N; i++) set_lane(i, 20000);
      start_job(4, 0, 1'b0);
      for (int b = 0; b < 4; b++) beat();
      wait_valid("satp");
      for (int i = 0; i < N; i++) check($sformatf("satp_lane%0d", i), lane(i), 32767);
      handshake("satp");
      for (int i = 0; i < N; i++) set_lane(i, -20000);
      start_job(4, 0, 1'b0);
      for (int b = 0; b < 4; b++) beat();
      wait_valid("satn");
      for (int i = 0; i < N; i++) check($sformatf("satn_lane%0d", i), lane(i), -32768);
      handshake("satn");

      // Gapped psum_valid, output backpressure, start ignored in DRAIN.
      psum_in = '0;
      set_lane(0, 1);
      start_job(3, 0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         psum_valid = pat[k][0];
         step();
      end
      psum_valid = 1'b0;
      check("gap_post_state", longint'(psum_ready), 0);
      step();
      check("gap_valid", longint'(out_valid), 1);
      check("gap_lane0", lane(0), 3);
      for (int k = 0; k < 5; k++) begin
         start = (k == 2);
         step();
         check($sformatf("bp_valid%0d", k), longint'(out_valid), 1);
         check($sformatf("bp_lane0_%0d", k), lane(0), 3);
         check($sformatf("bp_ready%0d", k), longint'(psum_ready), 0);
         check($sformatf("bp_busy%0d", k), longint'(busy), 1);
      end
      start = 1'b1;
      out_ready = 1'b1;
      step();
      start = 1'b0;
      out_ready = 1'b0;
      check("hs_done", longint'(done), 1);
      check("hs_start_ignored", longint'(busy), 0);
      step();
      check("hs_still_idle", longint'(busy), 0);
      check("hs_data_kept", lane(0), 3);

      // num_tiles of zero behaves as one.
      psum_in = '0;
      set_lane(0, 42);
      start_job(0, 0, 1'b0);
      beat();
      check("nt0_post", longint'(psum_ready), 0);
      wait_valid("nt0");
      check("nt0_lane0", lane(0), 42);
      handshake("nt0");

      // Reset in the middle of accumulation.
      set_lane(0, 9);
      start_job(5, 0, 1'b0);
      beat(); beat();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", longint'(busy), 0);
      check("mid_rst_ready", longint'(psum_ready), 0);
      check("mid_rst_valid", longint'(out_valid), 0);
      check("mid_rst_data", longint'(out_data == '0), 1);
      step();
      rst_n = 1'b1;
      step();
      set_lane(0, 7);
      start_job(1, 0, 1'b0);
      beat();
      wait_valid("post_rst");
      check("post_rst_lane0", lane(0), 7);
      handshake("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
